// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for N_MASTERS masters sharing one bus.
// Four-phase handshake: grant, wait for the owner to drive utilizing, hold, then one turnaround cycle.
module bus_arbiter #(
   parameter int N_MASTERS   = 3,
   parameter int TIMEOUT_LEN = 6
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [N_MASTERS-1:0] b_request,
   input  logic                 b_bus_utilizing,
   output logic [N_MASTERS-1:0] b_grant,
   output logic [2:0]           grant_id,
   output logic                 arb_busy
);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_GRANT_WAIT = 2'd1,
      ST_BUSY       = 2'd2,
      ST_RELEASE    = 2'd3
   } state_t;

   localparam logic [N_MASTERS-1:0]   GNT_NONE = {N_MASTERS{1'b0}};
   localparam logic [TIMEOUT_LEN-1:0] CNT_ZERO = {TIMEOUT_LEN{1'b0}};
   localparam logic [TIMEOUT_LEN-1:0] CNT_MAX  = {TIMEOUT_LEN{1'b1}};
   localparam logic [TIMEOUT_LEN-1:0] CNT_ONE  = {{(TIMEOUT_LEN-1){1'b0}}, 1'b1};

   state_t                 state_q;
   logic [N_MASTERS-1:0]   grant_q;
   logic [2:0]             grant_id_q;
   logic                   busy_q;
   logic [TIMEOUT_LEN-1:0] cnt_q;
   logic [2:0]             last_q;
   logic                   armed_q;

   logic [2:0]             cand_s;
   logic [2:0]             win_id_s;
   logic                   win_found_s;
   logic                   cnt_max_s;
   logic                   held_req_s;

   function automatic logic [N_MASTERS-1:0] onehot(input logic [2:0] idx);
      onehot = {{(N_MASTERS-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Round-robin search starting just after the previous winner, wrapping at N_MASTERS.
   always_comb begin
      cand_s      = 3'd0;
      win_id_s    = 3'd0;
      win_found_s = 1'b0;
      for (int i = 1; i <= N_MASTERS; i++) begin
         cand_s = 3'((int'(last_q) + i) % N_MASTERS);
         if (!win_found_s && (|(b_request & onehot(cand_s)))) begin
            win_id_s    = cand_s;
            win_found_s = 1'b1;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Timeout and withdrawal qualifiers for the current grant.
   always_comb begin
      cnt_max_s  = (cnt_q == CNT_MAX);
      held_req_s = |(b_request & grant_q);
   end

   // Arbitration FSM; all outputs are registered here so reset clears them asynchronously.
   // armed_q holds off the very first edge after reset so a grant never appears before the 2nd edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         grant_q    <= GNT_NONE;
         grant_id_q <= 3'd0;
         busy_q     <= 1'b0;
         cnt_q      <= CNT_ZERO;
         last_q     <= 3'(N_MASTERS - 1);
         armed_q    <= 1'b0;
      end else begin
         armed_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (armed_q && win_found_s && !b_bus_utilizing) begin
                  state_q    <= ST_GRANT_WAIT;
                  grant_q    <= onehot(win_id_s);
                  grant_id_q <= win_id_s;
                  last_q     <= win_id_s;
                  busy_q     <= 1'b1;
                  cnt_q      <= CNT_ZERO;
               end else begin
                  grant_q <= GNT_NONE;
                  busy_q  <= 1'b0;
               end
            end
            ST_GRANT_WAIT: begin
               if (b_bus_utilizing) begin
                  state_q <= ST_BUSY;
               end else if (!held_req_s || cnt_max_s) begin
                  state_q <= ST_RELEASE;
                  grant_q <= GNT_NONE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            ST_BUSY: begin
               if (!b_bus_utilizing) begin
                  state_q <= ST_RELEASE;
                  grant_q <= GNT_NONE;
               end else begin
                  state_q <= ST_BUSY;
               end
            end
            ST_RELEASE: begin
               state_q <= ST_IDLE;
               grant_q <= GNT_NONE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= GNT_NONE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign b_grant  = grant_q;
   assign grant_id = grant_id_q;
   assign arb_busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed table-driven bench for bus_arbiter (3 masters, 8-clock grant timeout).
module tb_bus_arbiter;

   logic       clk;
   logic       rstn;
   logic [2:0] b_request;
   logic       b_bus_utilizing;
   logic [2:0] b_grant;
   logic [2:0] grant_id;
   logic       arb_busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         rst;
      logic [2:0] req;
      logic       util;
      logic [2:0] grant;
      logic [2:0] id;
      logic       busy;
   } vec_t;

   vec_t vecs[$];

   bus_arbiter #(.N_MASTERS(3), .TIMEOUT_LEN(3)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .b_request       (b_request),
      .b_bus_utilizing (b_bus_utilizing),
      .b_grant         (b_grant),
      .grant_id        (grant_id),
      .arb_busy        (arb_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input bit r, input logic [2:0] req, input logic util,
                      input logic [2:0] g, input logic [2:0] id, input logic busy);
      vec_t v;
      v.rst = r; v.req = req; v.util = util; v.grant = g; v.id = id; v.busy = busy;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      rstn            = 1'b0;
      b_request       = 3'b000;
      b_bus_utilizing = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset grant", {5'd0, b_grant}, 8'h00);
      check("reset id", {5'd0, grant_id}, 8'h00);
      check("reset busy", {7'd0, arb_busy}, 8'h00);
      rstn = 1'b1;
   endtask

   task automatic step(input logic [2:0] req, input logic util);
      b_request       = req;
      b_bus_utilizing = util;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn            = 1'b0;
      b_request       = 3'b000;
      b_bus_utilizing = 1'b0;

      // single request: first edge after reset only arms, then grant, util after 3 clocks for 5
      add(1, 3'b000, 0, 3'b000, 3'd0, 0);
      add(0, 3'b001, 0, 3'b001, 3'd0, 1);
      add(0, 3'b001, 0, 3'b001, 3'd0, 1);
      add(0, 3'b001, 0, 3'b001, 3'd0, 1);
      add(0, 3'b001, 1, 3'b001, 3'd0, 1);
      add(0, 3'b001, 1, 3'b001, 3'd0, 1);
      add(0, 3'b001, 1, 3'b001, 3'd0, 1);
      add(0, 3'b000, 1, 3'b001, 3'd0, 1);
      add(0, 3'b000, 1, 3'b001, 3'd0, 1);
      add(0, 3'b000, 0, 3'b000, 3'd0, 1);
      add(0, 3'b000, 0, 3'b000, 3'd0, 0);
      add(0, 3'b000, 0, 3'b000, 3'd0, 0);
      // round robin with all three requesting
      add(1, 3'b111, 0, 3'b000, 3'd0, 0);
      add(0, 3'b111, 0, 3'b001, 3'd0, 1);
      add(0, 3'b111, 1, 3'b001, 3'd0, 1);
      add(0, 3'b111, 1, 3'b001, 3'd0, 1);
      add(0, 3'b111, 0, 3'b000, 3'd0, 1);
      add(0, 3'b111, 0, 3'b000, 3'd0, 0);
      add(0, 3'b111, 0, 3'b010, 3'd1, 1);
      add(0, 3'b111, 1, 3'b010, 3'd1, 1);
      add(0, 3'b111, 1, 3'b010, 3'd1, 1);
      add(0, 3'b111, 0, 3'b000, 3'd1, 1);
      add(0, 3'b111, 0, 3'b000, 3'd0, 0);
      add(0, 3'b111, 0, 3'b100, 3'd2, 1);
      add(0, 3'b111, 1, 3'b100, 3'd2, 1);
      add(0, 3'b111, 1, 3'b100, 3'd2, 1);
      add(0, 3'b111, 0, 3'b000, 3'd2, 1);
      add(0, 3'b111, 0, 3'b000, 3'd0, 0);
      add(0, 3'b111, 0, 3'b001, 3'd0, 1);
      add(0, 3'b000, 0, 3'b000, 3'd0, 1);
      add(0, 3'b000, 0, 3'b000, 3'd0, 0);
      // timeout: grant held exactly 8 clocks, then next arbitration skips master 1
      add(0, 3'b010, 0, 3'b010, 3'd1, 1);
      for (int i = 0; i < 7; i++) add(0, 3'b010, 0, 3'b010, 3'd1, 1);
      add(0, 3'b010, 0, 3'b000, 3'd1, 1);
      add(0, 3'b011, 0, 3'b000, 3'd0, 0);
      add(0, 3'b011, 0, 3'b001, 3'd0, 1);
      add(0, 3'b000, 0, 3'b000, 3'd0, 1);
      add(0, 3'b000, 0, 3'b000, 3'd0, 0);
      // withdrawal by master 2 before utilizing
      add(0, 3'b100, 0, 3'b100, 3'd2, 1);
      add(0, 3'b100, 0, 3'b100, 3'd2, 1);
      add(0, 3'b000, 0, 3'b000, 3'd2, 1);
      add(0, 3'b000, 0, 3'b000, 3'd0, 0);
      // stale utilizing blocks arbitration until it falls
      add(0, 3'b001, 1, 3'b000, 3'd0, 0);
      add(0, 3'b001, 1, 3'b000, 3'd0, 0);
      add(0, 3'b001, 0, 3'b001, 3'd0, 1);
      add(0, 3'b000, 0, 3'b000, 3'd0, 1);
      add(0, 3'b000, 0, 3'b000, 3'd0, 0);

      foreach (vecs[k]) begin
         if (vecs[k].rst) do_reset();
         step(vecs[k].req, vecs[k].util);
         check($sformatf("vec%0d grant", k), {5'd0, b_grant}, {5'd0, vecs[k].grant});
         check($sformatf("vec%0d busy", k), {7'd0, arb_busy}, {7'd0, vecs[k].busy});
         if (vecs[k].busy) check($sformatf("vec%0d id", k), {5'd0, grant_id}, {5'd0, vecs[k].id});
      end

      // reset asserted mid-BUSY drops the grant without waiting for a clock
      step(3'b100, 1'b0);
      check("midrst pre grant", {5'd0, b_grant}, 8'h04);
      step(3'b100, 1'b1);
      check("midrst busy grant", {5'd0, b_grant}, 8'h04);
      #3;
      rstn = 1'b0;
      #1;
      check("midrst async grant", {5'd0, b_grant}, 8'h00);
      check("midrst async busy", {7'd0, arb_busy}, 8'h00);
      check("midrst async id", {5'd0, grant_id}, 8'h00);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      step(3'b111, 1'b0);
      check("postrst first edge", {5'd0, b_grant}, 8'h00);
      step(3'b111, 1'b0);
      check("postrst grant m0", {5'd0, b_grant}, 8'h01);
      check("postrst id m0", {5'd0, grant_id}, 8'h00);
      step(3'b000, 1'b0);
      check("postrst withdraw", {5'd0, b_grant}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 3: number of requesting masters, legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT_LEN, default 6: grant-acceptance timeout counter width in bits, so the timeout is 2^TIMEOUT_LEN clocks.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port b_request, input, N_MASTERS bits: per-master bus request, active high, level-held by each master.
REQ-006 SHALL have port b_bus_utilizing, input, 1 bit: shared bus-in-use line, driven high by the master that owns the bus.
REQ-007 SHALL have port b_grant, output, N_MASTERS bits: one-hot-or-zero grant, registered.
REQ-008 SHALL have port grant_id, output, 3 bits: binary index of the current grant holder, valid while arb_busy=1.
REQ-009 SHALL have port arb_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 SHALL implement a state machine with states IDLE, GRANT_WAIT, BUSY and RELEASE.
REQ-011 IDLE: SHALL select a winner by round-robin when any b_request bit is high and b_bus_utilizing=0, searching from index (last_grant+1) mod N_MASTERS upward with wrap.
REQ-012 IDLE to GRANT_WAIT: SHALL set b_grant[winner]=1, grant_id=winner and last_grant=winner, visible 1 clock after the request is sampled.
REQ-013 IDLE with b_bus_utilizing=1 (foreign or stale owner): SHALL issue no grant and remain in IDLE.
REQ-014 GRANT_WAIT: SHALL hold the grant and count clocks from 0.
REQ-015 GRANT_WAIT to BUSY: SHALL occur on the first sampled b_bus_utilizing=1.
REQ-016 GRANT_WAIT to RELEASE (timeout): SHALL occur when the counter reaches 2^TIMEOUT_LEN-1 without b_bus_utilizing, clearing the grant.
REQ-017 GRANT_WAIT to RELEASE (withdrawal): SHALL occur when the granted master drops b_request before b_bus_utilizing rises, clearing the grant.
REQ-018 BUSY: SHALL keep b_grant asserted while b_bus_utilizing=1, regardless of b_request and of other masters' requests; no preemption.
REQ-019 BUSY to RELEASE: SHALL occur on the first sampled b_bus_utilizing=0, clearing b_grant on that edge.
REQ-020 RELEASE: SHALL drive b_grant=0 for exactly 1 clock, then go to IDLE; this gap guarantees a bus turnaround cycle.
REQ-021 b_grant SHALL never have more than one bit set in any cycle.
REQ-022 A request arriving in the same cycle as a release SHALL be arbitrated in the following IDLE cycle, so the minimum gap between grants is 2 clocks.
REQ-023 last_grant SHALL advance on timeout and on withdrawal as well, so a non-responding master cannot starve the others.
REQ-024 The timeout counter SHALL saturate and never wrap, and SHALL clear on every entry to GRANT_WAIT.
REQ-025 grant_id SHALL hold its last value in IDLE; it is don't-care to consumers while arb_busy=0.

Reset
REQ-026 While rstn=0: SHALL force state=IDLE, b_grant=0, grant_id=0, arb_busy=0, timeout counter=0 and last_grant=N_MASTERS-1, so master 0 wins first.
REQ-027 Reset asserted mid-GRANT_WAIT or mid-BUSY SHALL drop b_grant asynchronously in the same cycle.
REQ-028 After rstn deasserts, the first grant SHALL appear no earlier than the 2nd rising edge.

Verification
REQ-029 Single request: b_request=001 from reset, b_bus_utilizing raised 3 clocks after the grant and held for 5 clocks -> b_grant=001 for 1 clock after the request is sampled, held through BUSY, cleared on the edge that samples utilizing=0; 1-clock RELEASE; arb_busy=0 afterwards.
REQ-030 Round-robin: b_request=111 held, each owner uses the bus for 2 clocks -> grant order 001, 010, 100, 001 with b_grant=0 for at least 2 clocks between grants.
REQ-031 Timeout: TIMEOUT_LEN=3, b_request=010, b_bus_utilizing never asserted -> b_grant=010 for exactly 8 clocks, then 0; b_request=011 on the next arbitration grants 001.
REQ-032 Withdrawal: grant to master 2, b_request[2] dropped 2 clocks later with utilizing low -> b_grant clears on the next edge; state passes RELEASE then IDLE.
REQ-033 Reset mid-BUSY: rstn pulled low while b_grant=100 and utilizing=1 -> b_grant=000 immediately; after release, b_request=111 grants master 0 first.
REQ-034 Stale utilizing: b_bus_utilizing=1 in IDLE with b_request=001 -> no grant until utilizing falls, then grant within 1 clock.
